// File: rtl/mips_mem_responder_if.sv
// Core-side memory handshake bundle for mips_mem_responder.
interface mips_mem_responder_if;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_data_in;
  logic            mem_write_en;
  logic [3:0][7:0] mem_data_out;
  logic            mem_ready;
  logic            mem_busy;
  logic            mem_addr_err;

  modport master (
    output mem_req, mem_addr, mem_data_in, mem_write_en,
    input  mem_data_out, mem_ready, mem_busy, mem_addr_err
  );

  modport slave (
    input  mem_req, mem_addr, mem_data_in, mem_write_en,
    output mem_data_out, mem_ready, mem_busy, mem_addr_err
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Word-wide memory responder with fixed wait states and a one-cycle ready strobe.
// Optional address checking is enabled by defining MEM_ADDR_CHECK_EN.
module mips_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input logic                clk,
  input logic                rst_b,
  mips_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0][7:0] data_q, data_d;
  logic            we_q, we_d;

  logic [3:0][7:0] mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic            addr_bad;
  logic            resp_active;

  assign idx = addr_q[ADDR_BITS+1:2];

`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_BITS + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign addr_bad         = 1'b0;
  assign unused_addr_bits = ^{addr_q[31:ADDR_BITS+2], addr_q[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          addr_d = bus.mem_addr;
          data_d = bus.mem_data_in;
          we_d   = bus.mem_write_en;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet whenever reset is asserted, even mid-response.
  assign resp_active = (state_q == RESP) && !rst_b;

  always_comb begin
    bus.mem_busy     = (state_q != IDLE) && !rst_b;
    bus.mem_ready    = resp_active;
    bus.mem_addr_err = resp_active && addr_bad;
    bus.mem_data_out = '0;
    if (resp_active && !we_q && !addr_bad) bus.mem_data_out = mem_q[idx];
  end

  // Storage has no reset; a write lands only on an un-reset edge ending RESP.
  always_ff @(posedge clk) begin
    if (resp_active && we_q && !addr_bad) mem_q[idx] <= data_q;
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 secondary).
module tb_mips_mem_responder;

  localparam int WS  = 2;
  localparam int LAT = WS + 1;

  logic clk;
  logic rst_b;

  int tests_run;
  int tests_failed;

  // Reference storage: word index -> 32-bit word
  logic [31:0] model [int];

  mips_mem_responder_if ifc ();
  mips_mem_responder_if if0 ();

  mips_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_b(rst_b), .bus(ifc)
  );

  mips_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .bus(if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  // Issue one transaction from an IDLE negedge; returns at the next IDLE negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err,
                     output int lat, output int busy_n, output int stray);
    rdata  = 32'hxxxx_xxxx;
    err    = 1'bx;
    busy_n = 0;
    stray  = 0;
    ifc.mem_req      = 1'b1;
    ifc.mem_write_en = we;
    ifc.mem_addr     = addr;
    ifc.mem_data_in  = wdata;
    @(posedge clk);
    #1;
    ifc.mem_req      = 1'b0;
    ifc.mem_addr     = $urandom;
    ifc.mem_data_in  = $urandom;
    ifc.mem_write_en = 1'($urandom_range(1));
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.mem_busy) busy_n++;
      if (ifc.mem_ready) begin
        rdata = ifc.mem_data_out;
        err   = ifc.mem_addr_err;
        break;
      end
      if (ifc.mem_data_out !== 32'd0 || ifc.mem_addr_err !== 1'b0) stray++;
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    if (ifc.mem_busy !== 1'b0 || ifc.mem_data_out !== 32'd0) stray++;
  endtask

  task automatic test_reset;
    rst_b = 1'b1;
    ifc.mem_req = 1'b0; ifc.mem_addr = '0; ifc.mem_data_in = '0; ifc.mem_write_en = 1'b0;
    if0.mem_req = 1'b0; if0.mem_addr = '0; if0.mem_data_in = '0; if0.mem_write_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({ifc.mem_ready, ifc.mem_busy, ifc.mem_addr_err, ifc.mem_data_out} !== 35'd0) begin
      $display("FAIL reset_outputs got %h want 0",
               {ifc.mem_ready, ifc.mem_busy, ifc.mem_addr_err, ifc.mem_data_out});
      tests_failed++;
    end
    tests_run++;
    if ({if0.mem_ready, if0.mem_busy, if0.mem_addr_err, if0.mem_data_out} !== 35'd0) begin
      $display("FAIL reset_outputs_ws0 got %h want 0",
               {if0.mem_ready, if0.mem_busy, if0.mem_addr_err, if0.mem_data_out});
      tests_failed++;
    end
    rst_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic        er;
    int          lat, bsy, stray;
    txn(1'b1, 32'h100, 32'hDEADBEEF, rd, er, lat, bsy, stray);
    model[widx(32'h100)] = 32'hDEADBEEF;
    tests_run++;
    if (lat !== LAT || bsy !== LAT) begin
      $display("FAIL wr_timing latency %0d busy %0d want %0d/%0d", lat, bsy, LAT, LAT);
      tests_failed++;
    end
    tests_run++;
    if (rd !== 32'd0 || er !== 1'b0 || stray !== 0) begin
      $display("FAIL wr_resp data %h err %b stray %0d want 0/0/0", rd, er, stray);
      tests_failed++;
    end
    txn(1'b0, 32'h100, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (lat !== LAT || bsy !== LAT) begin
      $display("FAIL rd_timing latency %0d busy %0d want %0d/%0d", lat, bsy, LAT, LAT);
      tests_failed++;
    end
    tests_run++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || stray !== 0) begin
      $display("FAIL rd_data got %h err %b stray %0d want deadbeef/0/0", rd, er, stray);
      tests_failed++;
    end
  endtask

  task automatic test_random;
    int          keys[$];
    logic [31:0] rd, wd, exp;
    logic        er;
    int          lat, bsy, stray, k;
    logic        we;
    keys.push_back(widx(32'h100));
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(1));
      if (we) begin
        k  = int'($urandom_range(1023));
        wd = $urandom;
        txn(1'b1, 32'(k) << 2, wd, rd, er, lat, bsy, stray);
        if (!model.exists(k)) keys.push_back(k);
        model[k] = wd;
        exp = 32'd0;
      end else begin
        k   = keys[$urandom_range(keys.size() - 1)];
        txn(1'b0, 32'(k) << 2, $urandom, rd, er, lat, bsy, stray);
        exp = model[k];
      end
      tests_run++;
      if (rd !== exp || er !== 1'b0 || lat !== LAT || stray !== 0) begin
        $display("FAIL random_%0d we %b word %0d got %h err %b lat %0d stray %0d want %h/0/%0d/0",
                 n, we, k, rd, er, lat, stray, exp, LAT);
        tests_failed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, wd;
    logic        er;
    int          lat, bsy, stray;
    int          rdy[$];
    int          waited;
    wd = $urandom;
    txn(1'b1, 32'h0, wd, rd, er, lat, bsy, stray);
    model[0] = wd;
    for (int c = 0; c < 13; c++) begin
      if (ifc.mem_busy) begin
        ifc.mem_addr     = $urandom;
        ifc.mem_data_in  = $urandom;
        ifc.mem_write_en = 1'($urandom_range(1));
      end else begin
        ifc.mem_addr     = 32'h0;
        ifc.mem_write_en = 1'b0;
      end
      ifc.mem_req = 1'b1;
      if (ifc.mem_ready) begin
        rdy.push_back(c);
        tests_run++;
        if (ifc.mem_data_out !== model[0]) begin
          $display("FAIL held_data cycle %0d got %h want %h", c, ifc.mem_data_out, model[0]);
          tests_failed++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    ifc.mem_req = 1'b0;
    ifc.mem_addr = '0;
    ifc.mem_write_en = 1'b0;
    tests_run++;
    if (rdy.size() != 3 || rdy[0] != LAT || rdy[1] != LAT + WS + 2 || rdy[2] != LAT + 2 * (WS + 2)) begin
      $display("FAIL held_spacing ready count %0d first %0d want 3 at %0d step %0d",
               rdy.size(), (rdy.size() > 0) ? rdy[0] : -1, LAT, WS + 2);
      tests_failed++;
    end
    waited = 0;
    while (ifc.mem_busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (ifc.mem_busy !== 1'b0) begin
      $display("FAIL held_drain busy %b want 0", ifc.mem_busy);
      tests_failed++;
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, old;
    logic        er;
    int          lat, bsy, stray;
    logic        seen;
    old = $urandom;
    txn(1'b1, 32'h8, old, rd, er, lat, bsy, stray);
    model[2] = old;
    ifc.mem_req = 1'b1; ifc.mem_write_en = 1'b1;
    ifc.mem_addr = 32'h8; ifc.mem_data_in = 32'h11223344;
    @(posedge clk);
    #1;
    ifc.mem_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifc.mem_ready) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b1) begin
      $display("FAIL abort_reach_resp got %b want 1", seen);
      tests_failed++;
    end
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({ifc.mem_ready, ifc.mem_busy, ifc.mem_addr_err, ifc.mem_data_out} !== 35'd0) begin
      $display("FAIL abort_outputs got %h want 0",
               {ifc.mem_ready, ifc.mem_busy, ifc.mem_addr_err, ifc.mem_data_out});
      tests_failed++;
    end
    ifc.mem_req = 1'b1; ifc.mem_write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    ifc.mem_req = 1'b0;
    ifc.mem_write_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (ifc.mem_busy !== 1'b0) begin
      $display("FAIL req_in_reset busy got %b want 0", ifc.mem_busy);
      tests_failed++;
    end
    txn(1'b0, 32'h8, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (rd !== old) begin
      $display("FAIL abort_no_write got %h want %h", rd, old);
      tests_failed++;
    end
    txn(1'b0, 32'h100, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (rd !== model[widx(32'h100)]) begin
      $display("FAIL storage_kept got %h want %h", rd, model[widx(32'h100)]);
      tests_failed++;
    end
  endtask

  task automatic test_addr_check;
    logic [31:0] rd;
    logic        er;
    int          lat, bsy, stray;
    txn(1'b1, 32'h102, 32'hCAFEF00D, rd, er, lat, bsy, stray);
`ifdef MEM_ADDR_CHECK_EN
    tests_run++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== LAT || stray !== 0) begin
      $display("FAIL misaligned_err err %b data %h lat %0d stray %0d want 1/0/%0d/0", er, rd, lat, stray, LAT);
      tests_failed++;
    end
    txn(1'b0, 32'h100, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (rd !== model[widx(32'h100)] || er !== 1'b0) begin
      $display("FAIL err_no_write got %h err %b want %h/0", rd, er, model[widx(32'h100)]);
      tests_failed++;
    end
    txn(1'b0, 32'h2000, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== LAT) begin
      $display("FAIL range_err err %b data %h lat %0d want 1/0/%0d", er, rd, lat, LAT);
      tests_failed++;
    end
`else
    model[widx(32'h102)] = 32'hCAFEF00D;
    tests_run++;
    if (er !== 1'b0 || lat !== LAT) begin
      $display("FAIL unchecked_wr err %b lat %0d want 0/%0d", er, lat, LAT);
      tests_failed++;
    end
    txn(1'b0, 32'h100, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      $display("FAIL unchecked_store got %h err %b want cafef00d/0", rd, er);
      tests_failed++;
    end
    txn(1'b0, 32'h2000, 32'h0, rd, er, lat, bsy, stray);
    tests_run++;
    if (rd !== model[widx(32'h2000)] || er !== 1'b0) begin
      $display("FAIL unchecked_wrap got %h err %b want %h/0", rd, er, model[widx(32'h2000)]);
      tests_failed++;
    end
`endif
  endtask

  task automatic test_zero_wait;
    logic [31:0] wd;
    wd = $urandom;
    if0.mem_req = 1'b1; if0.mem_write_en = 1'b1;
    if0.mem_addr = 32'h4; if0.mem_data_in = wd;
    @(posedge clk);
    #1;
    if0.mem_req = 1'b0;
    if0.mem_data_in = $urandom;
    @(negedge clk);
    tests_run++;
    if (if0.mem_ready !== 1'b1 || if0.mem_data_out !== 32'd0) begin
      $display("FAIL ws0_write ready %b data %h want 1/0", if0.mem_ready, if0.mem_data_out);
      tests_failed++;
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (if0.mem_busy !== 1'b0 || if0.mem_ready !== 1'b0) begin
      $display("FAIL ws0_idle busy %b ready %b want 0/0", if0.mem_busy, if0.mem_ready);
      tests_failed++;
    end
    if0.mem_req = 1'b1; if0.mem_write_en = 1'b0;
    @(posedge clk);
    #1;
    if0.mem_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (if0.mem_ready !== 1'b1 || if0.mem_data_out !== wd) begin
      $display("FAIL ws0_read ready %b data %h want 1/%h", if0.mem_ready, if0.mem_data_out, wd);
      tests_failed++;
    end
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_addr_check();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 10, meaning the number of word-address bits (1024 words, 4 KB).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning the cycles between acceptance and the response; the legal range is 0..15.
REQ-003 The block SHALL have the following ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_b  in  1  reset; synchronous and active-high.
- mem_req  in  1  core access request.
- mem_addr  in  32  byte address from the core.
- mem_data_in  in  4x8  write data from the core; lane k is the byte at mem_addr+k.
- mem_write_en  in  1  1 = write, 0 = read.
- mem_data_out  out  4x8  read data to the core; lane k is the byte at word address+k.
- mem_ready  out  1  one-cycle response strobe.
- mem_busy  out  1  a transaction is in flight.
- mem_addr_err  out  1  error status of the current response.

Function
REQ-004 The block SHALL implement a three-state machine with states IDLE, WAIT and RESP.
REQ-005 In IDLE with mem_req=1, the block SHALL latch mem_addr, mem_data_in and mem_write_en, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-006 On entering WAIT, the block SHALL load a 4-bit counter with WAIT_STATES-1, decrement it every cycle, and go to RESP on the cycle after it reads 0.
REQ-007 mem_busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-008 mem_ready SHALL be 1 in RESP only, for exactly one cycle; the state after RESP SHALL be IDLE.
REQ-009 Acceptance-to-mem_ready latency SHALL be WAIT_STATES+1 cycles.
REQ-010 mem_req, mem_addr, mem_data_in and mem_write_en changes SHALL be ignored while mem_busy=1; only the latched values are used.
REQ-011 A mem_req held high in the cycle after mem_ready SHALL start a new transaction from IDLE, so the minimum request spacing is WAIT_STATES+2 cycles.
REQ-012 Storage SHALL be 2^ADDR_BITS words of 4 byte lanes, indexed by latched addr[ADDR_BITS+1:2].
REQ-013 A write SHALL commit all 4 lanes at the clock edge ending the RESP cycle; mem_data_out SHALL read 0 during a write response.
REQ-014 A read SHALL drive the addressed word on mem_data_out during the RESP cycle.
REQ-015 Outside RESP, mem_data_out SHALL be 0.
REQ-016 A read of a word written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-017 While rst_b=1 at a clock edge, the block SHALL enter IDLE, clear the counter and latches, and drive mem_ready=0, mem_busy=0, mem_addr_err=0 and mem_data_out=0.
REQ-018 Reset during WAIT or RESP SHALL abort the transaction and discard any pending write, including one in the RESP cycle coincident with reset.
REQ-019 Storage contents SHALL NOT be affected by reset.
REQ-020 mem_req asserted in the same cycle as rst_b=1 SHALL be ignored.

Configuration
REQ-021 With MEM_ADDR_CHECK_EN defined, a latched address with addr[1:0]!=0, or any bit above ADDR_BITS+1 set, SHALL make the response an error response.
REQ-022 An error response SHALL have mem_addr_err=1 and mem_data_out=0, SHALL suppress the write, and SHALL keep the normal latency.
REQ-023 mem_addr_err SHALL be valid only in the RESP cycle and SHALL be 0 at all other times.
REQ-024 Without MEM_ADDR_CHECK_EN, the block SHALL ignore addr[1:0] and the upper address bits, and SHALL tie mem_addr_err to 0.

Verification (WAIT_STATES=2 unless noted)
REQ-025 Write then read: write 0x100, data {DE,AD,BE,EF}; then read 0x100 -> mem_ready 3 cycles after each acceptance; read returns {DE,AD,BE,EF}; mem_busy high 3 cycles per transaction.
REQ-026 Held request: mem_req held 10 cycles, reads of 0x0 -> mem_ready every 4 cycles; mem_addr changes during busy ignored.
REQ-027 Zero wait: WAIT_STATES=0, read 0x4 -> mem_ready on the cycle after acceptance.
REQ-028 Reset abort: start write 0x8, data 0x11223344, assert rst_b in RESP; then read 0x8 -> prior contents returned; all outputs 0 during reset.
REQ-029 Bad address, MEM_ADDR_CHECK_EN defined: write 0x102 -> mem_addr_err=1 with mem_ready, no write; address 0x2000 (ADDR_BITS=10) -> mem_addr_err=1.
REQ-030 Bad address, MEM_ADDR_CHECK_EN undefined: write 0x102 -> stored at word 0x40 with mem_addr_err=0.
